// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: bundle between the number-producing logic (master) and
// the display scan controller (slave).
//   load        : one-cycle strobe, writes load_data into the shadow buffer
//   load_data   : eight BCD nibbles, nibble i = digit i, digit 0 rightmost
//   digit_en    : per-digit enable, 1 = shown (sampled live)
//   lz_blank    : 1 = blank leading zeros (sampled live)
//   anodes      : active-low anode drive (registered)
//   bcd_out     : nibble for the BCD-to-7-segment decoder (registered)
//   pending     : shadow holds data not yet shown
//   frame_start : one-cycle pulse when the scan wraps to digit 0
interface seg_scan_ctrl_if;
  logic        load;
  logic [31:0] load_data;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [7:0]  anodes;
  logic [3:0]  bcd_out;
  logic        pending;
  logic        frame_start;

  modport master (
    output load, load_data, digit_en, lz_blank,
    input  anodes, bcd_out, pending, frame_start
  );

  modport slave (
    input  load, load_data, digit_en, lz_blank,
    output anodes, bcd_out, pending, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexing scheduler for the 8-digit common-anode
// seven-segment display. Owns the refresh timebase, the digit scan, a
// double-buffered digit store, per-digit enables and leading-zero blanking.
// Ports:
//   clk_5MHz : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : seg_scan_ctrl_if slave (load/load_data/digit_en/lz_blank in,
//              anodes/bcd_out/pending/frame_start out)
// Parameters:
//   DIVISOR    : clk_5MHz cycles per digit slot (2..65535)
//   NUM_DIGITS : digits scanned (1..8); higher anodes stay high
module seg_scan_ctrl #(
  parameter int DIVISOR    = 10000,
  parameter int NUM_DIGITS = 8
) (
  input  logic           clk_5MHz,
  input  logic           reset_n,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [15:0] RELOAD = 16'(DIVISOR - 1);
  localparam logic [2:0]  LAST   = 3'(NUM_DIGITS - 1);
  localparam int unsigned ND     = NUM_DIGITS;

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        tick;
  logic        wrap;

  logic [31:0] active_buf;
  logic [31:0] shadow_buf;
  logic        pending_q;
  logic        frame_start_q;

  logic [7:0]  lz_mask;
  logic        zero_run;
  logic        blank;
  logic [7:0]  anodes_d;
  logic [3:0]  bcd_d;
  logic [7:0]  anodes_q;
  logic [3:0]  bcd_q;

  assign tick = (cnt == '0);
  assign wrap = tick && (idx == LAST);

  // Timebase and scan index
  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
      idx <= '0;
    end else if (tick) begin
      cnt <= RELOAD;
      idx <= wrap ? '0 : idx + 3'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  // Double buffer: the active buffer only changes on the wrap tick, so a
  // frame is never torn. A load landing on the wrap tick bypasses the shadow.
  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      active_buf    <= '0;
      shadow_buf    <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (bus.load)
        shadow_buf <= bus.load_data;
      if (wrap) begin
        pending_q <= 1'b0;
        if (bus.load)
          active_buf <= bus.load_data;
        else if (pending_q)
          active_buf <= shadow_buf;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
      frame_start_q <= wrap;
    end
  end

  // Leading-zero mask: walk from the top scanned digit down; a digit is a
  // leading zero while it and every scanned digit above it are zero.
  // Digit 0 is never marked so all-zero data still shows one "0".
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if ((7 - k) < ND) begin
        zero_run = zero_run && (active_buf[4*(7-k) +: 4] == 4'd0);
        lz_mask[7-k] = zero_run && (k != 7);
      end
    end
  end

  always_comb begin
    blank    = !bus.digit_en[idx] || (bus.lz_blank && lz_mask[idx]);
    anodes_d = blank ? 8'hFF : ~(8'd1 << idx);
    bcd_d    = active_buf[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      anodes_q <= 8'hFF;
      bcd_q    <= '0;
    end else begin
      anodes_q <= anodes_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bus.anodes      = anodes_q;
  assign bus.bcd_out     = bcd_q;
  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: dut1 (DIVISOR=4, NUM_DIGITS=8) and
// dut2 (DIVISOR=4, NUM_DIGITS=3). Stimulus pushes per-cycle expectations
// into a queue; the monitor compares every entry due on the current cycle.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;

  always #100 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_ctrl_if bus1 ();
  seg_scan_ctrl_if bus2 ();

  seg_scan_ctrl #(.DIVISOR(4), .NUM_DIGITS(8)) dut1 (
    .clk_5MHz(clk), .reset_n(reset_n), .bus(bus1)
  );
  seg_scan_ctrl #(.DIVISOR(4), .NUM_DIGITS(3)) dut2 (
    .clk_5MHz(clk), .reset_n(reset_n), .bus(bus2)
  );

  typedef struct {
    int          cyc;
    int          rel;
    int          sel;
    bit          is_pend;
    logic [7:0]  an;
    logic [3:0]  bcd;
    logic        fs;
    logic        pend;
  } exp_t;

  exp_t q[$];

  logic [7:0] an_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input int sel, input int f, input int nd,
                            input logic [31:0] data, input logic [7:0] shown,
                            input int nmax);
    exp_t e;
    int d;
    for (int n = 1; n <= nmax; n++) begin
      d = (n - 1) / 4;
      e.rel     = 4*nd*f + n;
      e.cyc     = base + e.rel;
      e.sel     = sel;
      e.is_pend = 1'b0;
      e.an      = shown[d] ? an_tbl[d] : 8'hFF;
      e.bcd     = data[4*d +: 4];
      e.fs      = (n == 4*nd);
      e.pend    = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic push_pend(input int n, input logic p);
    exp_t e;
    e.rel = n; e.cyc = base + n; e.sel = 1; e.is_pend = 1'b1;
    e.an = '0; e.bcd = '0; e.fs = 1'b0; e.pend = p;
    q.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic do_load(input int n, input logic [31:0] d);
    wait_edge(n - 1);
    bus1.load = 1'b1;
    bus1.load_data = d;
    wait_edge(n);
    bus1.load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an1"},  32'(bus1.anodes), 32'hFF);
    chk({tag, "_bcd1"}, 32'(bus1.bcd_out), 32'h0);
    chk({tag, "_pnd1"}, 32'(bus1.pending), 32'h0);
    chk({tag, "_fs1"},  32'(bus1.frame_start), 32'h0);
    chk({tag, "_an2"},  32'(bus2.anodes), 32'hFF);
  endtask

  // Monitor
  always @(negedge clk) begin
    chk("onehot1", 32'($onehot0(~bus1.anodes)), 32'd1);
    chk("hi_an2", 32'(bus2.anodes[7:3]), 32'h1F);
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc < cyc) begin
        chk($sformatf("late_d%0d@%0d", q[k].sel, q[k].rel), 32'(cyc), 32'(q[k].cyc));
        q.delete(k);
      end else if (q[k].cyc == cyc) begin
        if (q[k].is_pend) begin
          chk($sformatf("pend@%0d", q[k].rel), 32'(bus1.pending), 32'(q[k].pend));
        end else if (q[k].sel == 1) begin
          chk($sformatf("an1@%0d", q[k].rel),  32'(bus1.anodes), 32'(q[k].an));
          chk($sformatf("bcd1@%0d", q[k].rel), 32'(bus1.bcd_out), 32'(q[k].bcd));
          chk($sformatf("fs1@%0d", q[k].rel),  32'(bus1.frame_start), 32'(q[k].fs));
        end else begin
          chk($sformatf("an2@%0d", q[k].rel),  32'(bus2.anodes), 32'(q[k].an));
          chk($sformatf("bcd2@%0d", q[k].rel), 32'(bus2.bcd_out), 32'(q[k].bcd));
          chk($sformatf("fs2@%0d", q[k].rel),  32'(bus2.frame_start), 32'(q[k].fs));
        end
        q.delete(k);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [31:0] f_data [12] = '{32'h0, 32'h0, 32'h0, 32'h87654321, 32'h87654321,
                               32'h22222222, 32'h00000009, 32'h00000305, 32'h0,
                               32'h0, 32'h87654321, 32'h87654321};
  logic [7:0]  f_show [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h07, 8'h01, 8'h0F, 8'h0F, 8'h0F};

  initial begin
    bus1.load = 1'b0; bus1.load_data = '0; bus1.digit_en = 8'hFF; bus1.lz_blank = 1'b0;
    bus2.load = 1'b0; bus2.load_data = '0; bus2.digit_en = 8'hFF; bus2.lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");

    reset_n = 1'b1;
    base = cyc;
    for (int f = 0; f < 12; f++)
      push_frame(1, f, 8, f_data[f], f_show[f], (f == 11) ? 22 : 32);
    push_frame(2, 0, 3, 32'h0, 8'hFF, 12);
    push_frame(2, 1, 3, 32'h0, 8'hFF, 12);
    push_pend(1, 1'b0);
    push_pend(74, 1'b0);  push_pend(75, 1'b1);  push_pend(95, 1'b1);  push_pend(96, 1'b0);
    push_pend(130, 1'b1); push_pend(159, 1'b1); push_pend(160, 1'b0);
    push_pend(191, 1'b0); push_pend(192, 1'b0); push_pend(193, 1'b0);
    push_pend(200, 1'b1); push_pend(224, 1'b0);
    push_pend(240, 1'b1); push_pend(256, 1'b0);
    push_pend(290, 1'b1); push_pend(320, 1'b0);
    push_pend(360, 1'b1); push_pend(374, 1'b1);

    do_load(75, 32'h87654321);
    do_load(130, 32'h11111111);
    do_load(140, 32'h22222222);
    do_load(192, 32'h00000009);
    do_load(200, 32'h00000305);
    wait_edge(224);
    bus1.lz_blank = 1'b1;
    do_load(240, 32'h00000000);
    wait_edge(288);
    bus1.lz_blank = 1'b0;
    bus1.digit_en = 8'h0F;
    do_load(290, 32'h87654321);
    do_load(360, 32'hABCDEF01);

    // Reset mid slot 5 of frame 11 while pending is set
    wait_edge(374);
    #50;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    bus1.digit_en = 8'hFF;
    reset_n = 1'b1;
    base = cyc;
    push_frame(1, 0, 8, 32'h0, 8'hFF, 32);
    push_frame(2, 0, 3, 32'h0, 8'hFF, 12);
    push_frame(2, 1, 3, 32'h0, 8'hFF, 12);
    push_pend(1, 1'b0);
    push_pend(32, 1'b0);
    wait_edge(36);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
